m_stage_mem_access: RTL and testbench
=====================================

// Module: m_stage_mem_access
// PURPOSE
//  Consumer side of the EX/MEM pipeline register: takes the latched IR/PC/Y/V2, performs the
//  load/store against a handshaked data memory with variable latency, and returns aligned,
//  extended load data to the MEM/WB register.
//  Drives Stall_out, which holds the EX/MEM register (and earlier stages) while an access is
//  in flight.
// PARAMETERS
//  ADDR_W  32  byte-address width on the memory side
//  DATA_W  32  data width; fixed at 32, byte-lane logic assumes 4 lanes
// PORTS
//  Clk        in   1   clock, rising edge
//  Rst_n      in   1   asynchronous, active-low reset
//  IR_in      in   32  instruction from EX/MEM register
//  PC_in      in   32  PC of that instruction; used only for Exc_pc
//  Y_in       in   32  ALU result = effective byte address
//  V2_in      in   32  store source (rt value)
//  Stall_out  out  1   1 = freeze EX/MEM and upstream; insert bubble into MEM/WB
//  Mem_req    out  1   request valid toward data memory
//  Mem_we     out  1   1 = write, 0 = read
//  Mem_addr   out  32  word-aligned address ({Y[31:2],2'b00})
//  Mem_be     out  4   byte enables
//  Mem_wdata  out  32  lane-replicated store data
//  Mem_ready  in   1   memory accepts request this cycle
//  Mem_rvalid in   1   read data valid
//  Mem_rdata  in   32  raw read word
//  RD_out     out  32  extended load result to MEM/WB
//  Exc_out    out  1   misaligned access (AdEL/AdES) for current IR
//  Exc_pc     out  32  PC_in while Exc_out=1, else 0
// BEHAVIOUR
//  - Decoded ops (IR[31:26]): lb 20 lh 21 lw 23 lbu 24 lhu 25 sb 28 sh 29 sw 2b (hex). All
//    other opcodes are pass-through: Stall_out=0, no request.
//  - Misaligned: lw/sw with Y[1:0]!=0; lh/lhu/sh with Y[0]!=0.
//    Exc_out=1 combinationally; no request issued; Stall_out=0; FSM stays IDLE.
//  - FSM states: IDLE, REQ, RESP, DONE.
//    IDLE: aligned mem op present -> latch addr/be/wdata/op, go REQ.
//      Stall_out=1 (combinational, same cycle).
//    REQ: Mem_req=1; addr/be/wdata/we held stable until Mem_ready.
//      Ready on store -> DONE.
//      Ready on load -> RESP, or DONE if Mem_rvalid in the same cycle.
//    RESP: Mem_req=0; wait for Mem_rvalid; on rvalid capture extended data into RD_out,
//      go DONE.
//    DONE: Stall_out=0 for exactly 1 cycle so EX/MEM advances; return to IDLE; next IR
//      evaluated there.
//  - Stall_out = (IDLE & aligned mem op) | REQ | RESP.
//  - Latency, IR arrival to DONE: store >= 2 cycles; load >= 2 (rvalid with ready) or
//    >= 3 (rvalid later). Unbounded wait: no timeout.
//  - Store lanes, k = Y[1:0]:
//    sb: be = 1<<k, wdata = {4{V2[7:0]}}
//    sh: be = Y[1] ? 4'b1100 : 4'b0011, wdata = {2{V2[15:0]}}
//    sw: be = 4'hf, wdata = V2
//    Loads: Mem_be = 4'hf.
//  - Load extend: select byte k / half Y[1]; sign-extend for lb/lh, zero-extend for lbu/lhu.
//  - RD_out holds its value until the next captured load; it is not cleared by stores.
//  - Mem_rvalid outside RESP/REQ is ignored.
//  - Reset (async, any state): state=IDLE; all outputs 0; latched addr/be/wdata/op = 0.
//    Mem_req drops immediately.
//    A response outstanding at reset is the memory's responsibility; this block ignores it.
// STRUCTURE
//  - Shared package m_mem_pkg: opcode constants, state encoding (2 bits), BE patterns.
//  - One combinational sub-module, mem_lane_unit: store BE/wdata generation, load
//    select/extend, misalignment detect.
//  - This module holds FSM + request/data registers only.
// TESTING
//  1. IR=sw, Y=0x100, V2=0xdeadbeef, Mem_ready=1 on first REQ cycle
//     -> Mem_addr=0x100, be=f, wdata=deadbeef; Stall 1,1 then 0 in DONE.
//  2. IR=lb, Y=0x203, Mem_rdata=0x80xxxxxx, rvalid 2 cycles after ready
//     -> RD_out=0xffffff80; Stall high through RESP.
//  3. IR=lhu, Y=0x202, rdata=0xbeef1234, rvalid with ready -> RD_out=0x0000beef; REQ->DONE direct.
//  4. IR=sb, Y=0x101, V2=0x000000a5 -> be=0010, wdata=0xa5a5a5a5.
//     Then IR=lw, Y=0x102 -> Exc_out=1, Exc_pc=PC_in, Mem_req=0, Stall_out=0.
//  5. Mem_ready held 0 for 5 cycles -> Mem_req/addr/be/wdata stable, Stall_out=1 throughout.
//  6. Rst_n low in RESP -> same-edge-independent: Mem_req=0, Stall_out=0, RD_out=0, state IDLE;
//     later rvalid ignored.

Source files
------------

// File: rtl/m_mem_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM encoding and byte-enable patterns.
// Helpers classify an opcode as load or store.
package m_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [3:0] BE_NONE    = 4'h0;
    localparam logic [3:0] BE_BYTE0   = 4'h1;
    localparam logic [3:0] BE_LO_HALF = 4'h3;
    localparam logic [3:0] BE_HI_HALF = 4'hc;
    localparam logic [3:0] BE_ALL     = 4'hf;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic: store byte enables / replicated write data, misalignment detect,
// and load byte/half selection with sign or zero extension.
module mem_lane_unit
    import m_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] v2_i,
    input  logic [5:0]        ld_op_i,
    input  logic [1:0]        ld_off_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              misalign_o,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_load_o  = is_load_op(op_i);
        is_store_o = is_store_op(op_i);

        misalign_o = 1'b0;
        case (op_i)
            OP_LW, OP_SW:          misalign_o = |off_i;
            OP_LH, OP_LHU, OP_SH:  misalign_o = off_i[0];
            default:               misalign_o = 1'b0;
        endcase

        be_o    = BE_ALL;
        wdata_o = v2_i;
        case (op_i)
            OP_SB: begin
                be_o    = BE_BYTE0 << off_i;
                wdata_o = {4{v2_i[7:0]}};
            end
            OP_SH: begin
                be_o    = off_i[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata_o = {2{v2_i[15:0]}};
            end
            default: begin
                be_o    = BE_ALL;
                wdata_o = v2_i;
            end
        endcase
    end

    // Little-endian lanes: byte k lives in bits [8k+7:8k].
    always_comb begin
        ld_byte = 8'h00;
        case (ld_off_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        ld_data_o = rdata_i;
        case (ld_op_i)
            OP_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data_o = {24'h0, ld_byte};
            OP_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data_o = {16'h0, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/m_stage_mem_access.sv
// MEM pipeline stage: runs one load/store per instruction against a handshaked,
// variable-latency data memory and stalls upstream while the access is in flight.
module m_stage_mem_access
    import m_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [31:0]       IR_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       Y_in,
    input  logic [DATA_W-1:0] V2_in,
    output logic              Stall_out,
    output logic              Mem_req,
    output logic              Mem_we,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [3:0]        Mem_be,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic              Mem_ready,
    input  logic              Mem_rvalid,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic [DATA_W-1:0] RD_out,
    output logic              Exc_out,
    output logic [31:0]       Exc_pc,
    output logic [1:0]        State_dbg
);

    // Handshake: a request transfers on any cycle where Mem_req && Mem_ready; the request
    // fields are held stable until then. Read data is taken on Mem_rvalid only while the
    // request is being accepted (REQ) or awaited (RESP); rvalid elsewhere is ignored.

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic              is_load, is_store, misalign;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata, ld_data;
    logic              mem_op_ok;
    logic              capture;
    logic              unused_ir;

    assign unused_ir = ^IR_in[25:0];

    mem_lane_unit #(.DATA_W(DATA_W)) u_lane (
        .op_i       (IR_in[31:26]),
        .off_i      (Y_in[1:0]),
        .v2_i       (V2_in),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .rdata_i    (Mem_rdata),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .misalign_o (misalign),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .ld_data_o  (ld_data)
    );

    assign mem_op_ok = (is_load | is_store) & ~misalign;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op_ok) state_d = ST_REQ;
            ST_REQ: begin
                if (Mem_ready) begin
                    if (we_q || Mem_rvalid) state_d = ST_DONE;
                    else                    state_d = ST_RESP;
                end
            end
            ST_RESP: if (Mem_rvalid) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall and exception are gated by reset so every output reads 0 while Rst_n is low.
    always_comb begin
        Mem_req   = (state_q == ST_REQ);
        Stall_out = Rst_n & (((state_q == ST_IDLE) & mem_op_ok) |
                             (state_q == ST_REQ) | (state_q == ST_RESP));
        Exc_out   = Rst_n & (is_load | is_store) & misalign;
        Exc_pc    = Exc_out ? PC_in : 32'h0;
        Mem_we    = we_q;
        Mem_addr  = addr_q;
        Mem_be    = be_q;
        Mem_wdata = wdata_q;
        RD_out    = rd_q;
        State_dbg = state_q;
    end

    always_comb begin
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        op_d    = op_q;
        off_d   = off_q;
        if ((state_q == ST_IDLE) && mem_op_ok) begin
            addr_d  = {Y_in[ADDR_W-1:2], 2'b00};
            be_d    = is_store ? lane_be : BE_ALL;
            wdata_d = is_store ? lane_wdata : '0;
            we_d    = is_store;
            op_d    = IR_in[31:26];
            off_d   = Y_in[1:0];
        end
        capture = ((state_q == ST_REQ) & Mem_ready & ~we_q & Mem_rvalid) |
                  ((state_q == ST_RESP) & Mem_rvalid);
        rd_d    = capture ? ld_data : rd_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q  <= '0;
            be_q    <= BE_NONE;
            wdata_q <= '0;
            we_q    <= 1'b0;
            op_q    <= 6'h0;
            off_q   <= 2'b00;
            rd_q    <= '0;
        end else begin
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            op_q    <= op_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_m_stage_mem_access.sv
// Directed and randomized checks of the MEM stage against a byte-level reference model
// and a cycle-by-cycle handshaking memory driver.
module tb_m_stage_mem_access;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] IR_in, PC_in, Y_in, V2_in;
    logic        Stall_out, Mem_req, Mem_we;
    logic [31:0] Mem_addr;
    logic [3:0]  Mem_be;
    logic [31:0] Mem_wdata;
    logic        Mem_ready, Mem_rvalid;
    logic [31:0] Mem_rdata;
    logic [31:0] RD_out;
    logic        Exc_out;
    logic [31:0] Exc_pc;
    logic [1:0]  State_dbg;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rd = 32'h0;

    m_stage_mem_access dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .IR_in      (IR_in),
        .PC_in      (PC_in),
        .Y_in       (Y_in),
        .V2_in      (V2_in),
        .Stall_out  (Stall_out),
        .Mem_req    (Mem_req),
        .Mem_we     (Mem_we),
        .Mem_addr   (Mem_addr),
        .Mem_be     (Mem_be),
        .Mem_wdata  (Mem_wdata),
        .Mem_ready  (Mem_ready),
        .Mem_rvalid (Mem_rvalid),
        .Mem_rdata  (Mem_rdata),
        .RD_out     (RD_out),
        .Exc_out    (Exc_out),
        .Exc_pc     (Exc_pc),
        .State_dbg  (State_dbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Access size in bytes, 0 for non-memory opcodes.
    function automatic int op_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2b:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [5:0] op);
        return op >= 6'h28;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] y);
        int sz, k;
        sz = op_size(op);
        k  = int'(y % 4);
        if (!op_is_store(op) || sz == 4) return 4'hf;
        return 4'((sz == 1 ? 1 : 3) << k);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] v2);
        int sz;
        sz = op_size(op);
        if (sz == 1) return (v2 % 256) * 32'h01010101;
        if (sz == 2) return (v2 % 65536) * 32'h00010001;
        return v2;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] y,
                                               input logic [31:0] word);
        int sz, k;
        longint v;
        bit sgn;
        sz  = op_size(op);
        k   = int'(y % 4);
        sgn = (op == 6'h20) || (op == 6'h21);
        if (sz == 4) return word;
        v = longint'((word >> (8 * k)) % (sz == 1 ? 256 : 65536));
        if (sgn && v >= (sz == 1 ? 128 : 32768)) v = v - (sz == 1 ? 256 : 65536);
        return 32'(v);
    endfunction

    task automatic do_access(input logic [5:0] op, input logic [31:0] y, input logic [31:0] v2,
                             input logic [31:0] pc, input logic [31:0] rd_word,
                             input int rdy_dly, input int rv_dly);
        int  sz;
        bit  st, mis;
        sz  = op_size(op);
        st  = op_is_store(op);
        mis = (sz != 0) && ((y % sz) != 0);
        IR_in = {op, 26'h0abcdef};
        Y_in = y; V2_in = v2; PC_in = pc;
        Mem_ready = 1'b0; Mem_rvalid = 1'b0; Mem_rdata = $urandom;
        #1;
        if (sz == 0 || mis) begin
            chk("pass_stall", {31'h0, Stall_out}, 32'h0);
            chk("pass_req", {31'h0, Mem_req}, 32'h0);
            chk("exc", {31'h0, Exc_out}, {31'h0, mis});
            chk("exc_pc", Exc_pc, mis ? pc : 32'h0);
            tick();
            chk("pass_state", {30'h0, State_dbg}, 32'h0);
            return;
        end
        if (!st) exp_q.push_back(model_load(op, y, rd_word));
        chk("idle_stall", {31'h0, Stall_out}, 32'h1);
        chk("idle_req", {31'h0, Mem_req}, 32'h0);
        chk("idle_exc", {31'h0, Exc_out}, 32'h0);
        tick();
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i == rdy_dly) begin
                Mem_ready = 1'b1;
                if (!st && rv_dly == 0) begin
                    Mem_rvalid = 1'b1;
                    Mem_rdata  = rd_word;
                end
            end
            #1;
            chk("req_req", {31'h0, Mem_req}, 32'h1);
            chk("req_stall", {31'h0, Stall_out}, 32'h1);
            chk("req_addr", Mem_addr, y & 32'hffff_fffc);
            chk("req_be", {28'h0, Mem_be}, {28'h0, model_be(op, y)});
            chk("req_we", {31'h0, Mem_we}, {31'h0, st});
            if (st) chk("req_wdata", Mem_wdata, model_wdata(op, v2));
            tick();
        end
        Mem_ready = 1'b0; Mem_rvalid = 1'b0; Mem_rdata = $urandom;
        if (!st && rv_dly > 0) begin
            for (int i = 1; i <= rv_dly; i++) begin
                if (i == rv_dly) begin
                    Mem_rvalid = 1'b1;
                    Mem_rdata  = rd_word;
                end
                #1;
                chk("resp_req", {31'h0, Mem_req}, 32'h0);
                chk("resp_stall", {31'h0, Stall_out}, 32'h1);
                chk("resp_state", {30'h0, State_dbg}, 32'h2);
                tick();
            end
            Mem_rvalid = 1'b0;
        end
        if (!st) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'h1, 32'h0);
            else exp_rd = exp_q.pop_front();
        end
        #1;
        chk("done_stall", {31'h0, Stall_out}, 32'h0);
        chk("done_req", {31'h0, Mem_req}, 32'h0);
        chk("done_state", {30'h0, State_dbg}, 32'h3);
        chk("done_rd", RD_out, exp_rd);
        tick();
    endtask

    initial begin
        logic [5:0] ops [10];
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h00, 6'h0f};

        Rst_n = 1'b0;
        IR_in = 32'h0; PC_in = 32'h0; Y_in = 32'h0; V2_in = 32'h0;
        Mem_ready = 1'b0; Mem_rvalid = 1'b0; Mem_rdata = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_req", {31'h0, Mem_req}, 32'h0);
        chk("rst_stall", {31'h0, Stall_out}, 32'h0);
        chk("rst_rd", RD_out, 32'h0);
        chk("rst_addr", Mem_addr, 32'h0);
        chk("rst_be", {28'h0, Mem_be}, 32'h0);
        chk("rst_state", {30'h0, State_dbg}, 32'h0);
        Rst_n = 1'b1;
        tick();

        do_access(6'h2b, 32'h100, 32'hdeadbeef, 32'h400, 32'h0, 0, 0);
        do_access(6'h20, 32'h203, 32'h0, 32'h404, 32'h80123456, 0, 2);
        chk("t2_rd", RD_out, 32'hffffff80);
        do_access(6'h25, 32'h202, 32'h0, 32'h408, 32'hbeef1234, 0, 0);
        chk("t3_rd", RD_out, 32'h0000beef);
        do_access(6'h28, 32'h101, 32'h000000a5, 32'h40c, 32'h0, 0, 0);
        chk("t4_rd_kept", RD_out, 32'h0000beef);
        do_access(6'h23, 32'h102, 32'h0, 32'h410, 32'h0, 0, 0);
        do_access(6'h2b, 32'h104, 32'h12345678, 32'h414, 32'h0, 5, 0);

        // Reset asserted while waiting for read data.
        IR_in = {6'h23, 26'h0}; Y_in = 32'h300; PC_in = 32'h418;
        Mem_ready = 1'b0; Mem_rvalid = 1'b0;
        tick();
        Mem_ready = 1'b1;
        tick();
        Mem_ready = 1'b0;
        #1;
        chk("r6_in_resp", {30'h0, State_dbg}, 32'h2);
        Rst_n = 1'b0;
        #1;
        chk("r6_req", {31'h0, Mem_req}, 32'h0);
        chk("r6_stall", {31'h0, Stall_out}, 32'h0);
        chk("r6_rd", RD_out, 32'h0);
        chk("r6_state", {30'h0, State_dbg}, 32'h0);
        IR_in = 32'h0;
        tick();
        Rst_n = 1'b1;
        tick();
        Mem_rvalid = 1'b1; Mem_rdata = 32'hffffffff;
        #1;
        chk("r6_late_stall", {31'h0, Stall_out}, 32'h0);
        tick();
        Mem_rvalid = 1'b0;
        chk("r6_late_rd", RD_out, 32'h0);
        chk("r6_late_state", {30'h0, State_dbg}, 32'h0);
        exp_rd = 32'h0;
        exp_q.delete();

        for (int n = 0; n < 60; n++) begin
            do_access(ops[$urandom_range(0, 9)], $urandom_range(0, 4095), $urandom,
                      $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
